mod_counter_div: RTL and testbench

//  Parametrised modulo up/down counter with synchronous load and built-in clock-divider outputs.

---
 rtl/mod_counter_div_pkg.sv | 10 +
 rtl/div_toggle.sv | 31 +++
 rtl/mod_counter_div.sv | 74 +++++++
 tb/tb_mod_counter_div.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_div_pkg.sv
// Shared constants for the modulo counter / clock-divider time base.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mod_counter_div_pkg;

    localparam int   CLKDIV_DEF_WIDTH = 8;
    localparam logic CNT_UP           = 1'b1;
    localparam logic CNT_DN           = 1'b0;

endpackage

// File: rtl/div_toggle.sv
// T flop with async active-low clear; produces the 50% duty divided output.
// Latency: q flips one clk after t is sampled high.
// Backpressure: none; t is a single-cycle strobe.
module div_toggle (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mod_counter_div.sv
// Modulo up/down counter with clamped load, terminal-count pulse and divided output.
// Latency: count/tc/div_out all registered, 1 clk from sampled inputs.
// Backpressure: none; en gates counting, ld overrides en.
module mod_counter_div
    import mod_counter_div_pkg::*;
#(
    parameter int               WIDTH   = CLKDIV_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic             up,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             wrap;

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (ld) begin
            count_d = (din > mod_val) ? mod_val : din;
        end else if (en) begin
            if (up == CNT_UP) begin
                // >= so a lowered mod_val still wraps instead of running past it
                if (count_q >= mod_val) begin
                    count_d = '0;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = mod_val;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
        tc_d = wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    div_toggle u_div_toggle (
        .clk   (clk),
        .rst_n (rst),
        .t     (wrap),
        .q     (div_out)
    );

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_mod_counter_div.sv
// Randomized and directed bench for mod_counter_div with an in-bench reference model.
module tb_mod_counter_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         ld = 1'b0;
    logic         up = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] mod_val = 8'd9;
    logic [W-1:0] count;
    logic         tc;
    logic         div_out;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference model state kept as plain integers.
    int m_cnt = 0;
    int m_tc  = 0;
    int m_div = 0;

    always #5 clk = ~clk;

    mod_counter_div #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ld      (ld),
        .up      (up),
        .din     (din),
        .mod_val (mod_val),
        .count   (count),
        .tc      (tc),
        .div_out (div_out)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0;
            m_tc  = 0;
            m_div = 0;
        end else begin
            int mv;
            mv   = int'(mod_val);
            m_tc = 0;
            if (ld) begin
                m_cnt = (int'(din) > mv) ? mv : int'(din);
            end else if (en) begin
                if (up) begin
                    if (m_cnt >= mv) begin
                        m_cnt = 0;
                        m_tc  = 1;
                        m_div = 1 - m_div;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        m_cnt = mv;
                        m_tc  = 1;
                        m_div = 1 - m_div;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_count", int'(count), m_cnt);
            check("model_tc", int'(tc), m_tc);
            check("model_div", int'(div_out), m_div);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int tcs;
        int found;
        bit exp_div;

        #50;
        check("reset_count", int'(count), 0);
        check("reset_tc", int'(tc), 0);
        check("reset_div", int'(div_out), 0);
        #50;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_on = 1'b1;

        // Up count mod 9 to 5, then hold for 4 clks.
        en = 1'b1; up = 1'b1; mod_val = 8'd9;
        repeat (5) step();
        check("up_to5", int'(count), 5);
        en = 1'b0;
        repeat (4) step();
        check("hold_count", int'(count), 5);
        check("hold_tc", int'(tc), 0);
        check("hold_div", int'(div_out), 0);
        en = 1'b1;
        step();
        check("resume6", int'(count), 6);
        repeat (4) step();
        check("wrap_count", int'(count), 0);
        check("wrap_tc", int'(tc), 1);
        check("wrap_div", int'(div_out), 1);
        step();
        check("tc_one_cycle", int'(tc), 0);

        // Clamped load beats en.
        ld = 1'b1; din = 8'd200;
        step();
        check("load_clamp", int'(count), 9);
        check("load_tc", int'(tc), 0);
        check("load_div_keep", int'(div_out), 1);

        // Down count mod 3 from 0.
        din = 8'd0;
        step();
        check("load_zero", int'(count), 0);
        ld = 1'b0; up = 1'b0; mod_val = 8'd3;
        step();
        check("dn_reload", int'(count), 3);
        check("dn_reload_tc", int'(tc), 1);
        check("dn_reload_div", int'(div_out), 0);
        step();
        check("dn_2", int'(count), 2);
        repeat (3) step();
        check("dn_reload2", int'(count), 3);
        check("dn_reload2_tc", int'(tc), 1);
        check("dn_reload2_div", int'(div_out), 1);

        // mod_val = 0: tc every clk, div_out toggles every clk.
        up = 1'b1; mod_val = 8'd0;
        exp_div = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_div = ~exp_div;
            check("m0_count", int'(count), 0);
            check("m0_tc", int'(tc), 1);
            check("m0_div", int'(div_out), int'(exp_div));
        end

        // tc period is M+1 with steady enable.
        mod_val = 8'd9; ld = 1'b1; din = 8'd0;
        step();
        ld = 1'b0;
        tcs = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            tcs += int'(tc);
        end
        check("tc_per_30", tcs, 3);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            en = ($urandom_range(0, 99) < 80);
            ld = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 10) up = ~up;
            din = W'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 3) begin
                mod_val = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 255))
                                                        : W'($urandom_range(0, 5));
            end
            step();
        end

        // Async reset mid-count with count=7 and div_out=1.
        ld = 1'b0; en = 1'b1; up = 1'b1; mod_val = 8'd9;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_cnt == 7 && m_div == 1) begin
                found = 1;
                break;
            end
        end
        check("find_7_div1", found, 1);
        check("pre_rst_count", int'(count), 7);
        check("pre_rst_div", int'(div_out), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_tc", int'(tc), 0);
        check("async_rst_div", int'(div_out), 0);
        step();
        check("rst_hold_count", int'(count), 0);
        rst = 1'b1;
        step();
        check("post_rst_count", int'(count), 1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
